// File: rtl/soc_fpga_ram_code_reader.sv
// soc_fpga_ram_code_reader
//   Streams a burst of consecutive words out of a single-port RAM that has a
//   one-cycle registered read path. Each read is captured into a 2-entry
//   FIFO and presented on a valid/ready stream.
//
// Ports
//   PortAClk, PortAResetn     clock, asynchronous active-low reset
//   Start, BaseAddr, Length   burst request; sampled only while idle
//   Busy, Done                burst in progress / one-cycle completion pulse
//   PortAAddr                 RAM address (holds its last value when not reading)
//   PortAWriteEnable          tied 0
//   PortADataIn               tied 0
//   PortADataOut              RAM read data for the previous cycle's address
//   StreamData, StreamValid   output stream
//   StreamReady               stream consumer ready
module soc_fpga_ram_code_reader #(
   parameter int unsigned DATAWIDTH = 2,
   parameter int unsigned ADDRWIDTH = 2
) (
   input  logic                 PortAClk,
   input  logic                 PortAResetn,
   input  logic                 Start,
   input  logic [ADDRWIDTH-1:0] BaseAddr,
   input  logic [ADDRWIDTH:0]   Length,
   output logic                 Busy,
   output logic                 Done,
   output logic [ADDRWIDTH-1:0] PortAAddr,
   output logic                 PortAWriteEnable,
   output logic [DATAWIDTH-1:0] PortADataIn,
   input  logic [DATAWIDTH-1:0] PortADataOut,
   output logic [DATAWIDTH-1:0] StreamData,
   output logic                 StreamValid,
   input  logic                 StreamReady
);

   localparam int unsigned LenW = ADDRWIDTH + 1;

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e               state_q, state_d;
   logic [ADDRWIDTH-1:0] ptr_q, ptr_d;             // next address to read
   logic [ADDRWIDTH-1:0] last_addr_q, last_addr_d; // last address presented
   logic [LenW-1:0]      iss_left_q, iss_left_d;   // reads still to issue
   logic [LenW-1:0]      xfer_left_q, xfer_left_d; // words still to transfer
   logic                 cap_q, cap_d;             // read issued last cycle
   logic [DATAWIDTH-1:0] fifo_q [2];
   logic [DATAWIDTH-1:0] fifo_d [2];
   logic                 rd_idx_q, rd_idx_d;
   logic                 wr_idx_q, wr_idx_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 done_q, done_d;

   logic                 xfer;
   logic                 issue;
   logic [2:0]           credit;

   assign xfer   = (cnt_q != 2'd0) && StreamReady;
   // Occupancy the FIFO will have once this cycle's capture and transfer
   // settle; a new read is only safe if there is still a free slot for it.
   assign credit = 3'(cnt_q) + 3'(cap_q) - 3'(xfer);
   assign issue  = (state_q == StRead) && (iss_left_q != '0) && (credit < 3'd2);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      last_addr_d = last_addr_q;
      iss_left_d  = iss_left_q;
      xfer_left_d = xfer_left_q;
      cap_d       = issue;
      fifo_d      = fifo_q;
      rd_idx_d    = rd_idx_q;
      wr_idx_d    = wr_idx_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;

      if (issue) begin
         last_addr_d = ptr_q;
         ptr_d       = ptr_q + ADDRWIDTH'(1);
         iss_left_d  = iss_left_q - LenW'(1);
      end

      if (cap_q) begin
         fifo_d[wr_idx_q] = PortADataOut;
         wr_idx_d         = ~wr_idx_q;
      end

      if (xfer) begin
         rd_idx_d    = ~rd_idx_q;
         xfer_left_d = xfer_left_q - LenW'(1);
      end

      case ({cap_q, xfer})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               if (Length == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = StRead;
                  ptr_d       = BaseAddr;
                  iss_left_d  = Length;
                  xfer_left_d = Length;
               end
            end
         end
         StRead: begin
            if (issue && (iss_left_q == LenW'(1))) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (xfer && (xfer_left_q == LenW'(1))) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PortAClk or negedge PortAResetn) begin
      if (!PortAResetn) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         last_addr_q <= '0;
         iss_left_q  <= '0;
         xfer_left_q <= '0;
         cap_q       <= 1'b0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         rd_idx_q    <= 1'b0;
         wr_idx_q    <= 1'b0;
         cnt_q       <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         last_addr_q <= last_addr_d;
         iss_left_q  <= iss_left_d;
         xfer_left_q <= xfer_left_d;
         cap_q       <= cap_d;
         fifo_q[0]   <= fifo_d[0];
         fifo_q[1]   <= fifo_d[1];
         rd_idx_q    <= rd_idx_d;
         wr_idx_q    <= wr_idx_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
      end
   end

   // The address goes out in the same cycle the read is decided, so the RAM's
   // registered output lines up with cap_q one cycle later.
   assign PortAAddr        = issue ? ptr_q : last_addr_q;
   assign PortAWriteEnable = 1'b0;
   assign PortADataIn      = '0;
   assign StreamData       = fifo_q[rd_idx_q];
   assign StreamValid      = (cnt_q != 2'd0);
   assign Busy             = (state_q != StIdle);
   assign Done             = done_q;

endmodule

// File: tb/tb_soc_fpga_ram_code_reader.sv
module tb_soc_fpga_ram_code_reader;

   localparam int unsigned DW = 2;
   localparam int unsigned AW = 2;

   logic          clk;
   logic          rst_n;
   logic          Start;
   logic [AW-1:0] BaseAddr;
   logic [AW:0]   Length;
   logic          Busy;
   logic          Done;
   logic [AW-1:0] PortAAddr;
   logic          PortAWriteEnable;
   logic [DW-1:0] PortADataIn;
   logic [DW-1:0] PortADataOut;
   logic [DW-1:0] StreamData;
   logic          StreamValid;
   logic          StreamReady;

   logic [DW-1:0] mem [4];

   int n_tests;
   int n_fail;

   soc_fpga_ram_code_reader #(
      .DATAWIDTH(DW),
      .ADDRWIDTH(AW)
   ) dut (
      .PortAClk        (clk),
      .PortAResetn     (rst_n),
      .Start           (Start),
      .BaseAddr        (BaseAddr),
      .Length          (Length),
      .Busy            (Busy),
      .Done            (Done),
      .PortAAddr       (PortAAddr),
      .PortAWriteEnable(PortAWriteEnable),
      .PortADataIn     (PortADataIn),
      .PortADataOut    (PortADataOut),
      .StreamData      (StreamData),
      .StreamValid     (StreamValid),
      .StreamReady     (StreamReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with registered read
   always @(posedge clk) PortADataOut <= mem[PortAAddr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle (Start is a one-cycle pulse) and check at the falling edge.
   // data/addr < 0 means not checked.
   task automatic expect_cycle(input string tag, input int busy, input int done,
                               input int valid, input int data, input int addr);
      @(posedge clk);
      #1;
      Start = 1'b0;
      @(negedge clk);
      check({tag, ".busy"}, 32'(Busy), busy);
      check({tag, ".done"}, 32'(Done), done);
      check({tag, ".valid"}, 32'(StreamValid), valid);
      if (data >= 0) check({tag, ".data"}, 32'(StreamData), data);
      if (addr >= 0) check({tag, ".addr"}, 32'(PortAAddr), addr);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"}, 32'(Busy), 0);
      check({tag, ".done"}, 32'(Done), 0);
      check({tag, ".valid"}, 32'(StreamValid), 0);
      check({tag, ".data"}, 32'(StreamData), 0);
      check({tag, ".addr"}, 32'(PortAAddr), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            pat3 [6];
      int            exp3 [4];
      logic [DW-1:0] q3 [$];
      logic          stalled;
      logic [DW-1:0] held;
      logic          seen_done;
      logic [31:0]   got;

      n_tests = 0;
      n_fail  = 0;
      mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3; mem[3] = 2'd0;
      pat3 = '{1, 0, 0, 1, 0, 1};
      exp3 = '{1, 2, 3, 0};
      Start = 1'b0; BaseAddr = '0; Length = '0; StreamReady = 1'b1;

      // Reset
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("reset");
      check("reset.we", 32'(PortAWriteEnable), 0);
      check("reset.din", 32'(PortADataIn), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Burst 0..3, ready high
      Start = 1'b1; BaseAddr = 2'd0; Length = 3'd4; StreamReady = 1'b1;
      expect_cycle("b1.c1", 1, 0, 0, -1, 0);
      expect_cycle("b1.c2", 1, 0, 0, -1, 1);
      expect_cycle("b1.c3", 1, 0, 1, 1, 2);
      expect_cycle("b1.c4", 1, 0, 1, 2, 3);
      expect_cycle("b1.c5", 1, 0, 1, 3, 3);
      expect_cycle("b1.c6", 1, 0, 1, 0, 3);
      expect_cycle("b1.c7", 0, 1, 0, -1, 3);
      expect_cycle("b1.c8", 0, 0, 0, -1, 3);

      // Wrapping burst 3,0,1
      Start = 1'b1; BaseAddr = 2'd3; Length = 3'd3;
      expect_cycle("b2.c1", 1, 0, 0, -1, 3);
      expect_cycle("b2.c2", 1, 0, 0, -1, 0);
      expect_cycle("b2.c3", 1, 0, 1, 0, 1);
      expect_cycle("b2.c4", 1, 0, 1, 1, 1);
      expect_cycle("b2.c5", 1, 0, 1, 2, 1);
      expect_cycle("b2.c6", 0, 1, 0, -1, 1);

      // Backpressure: ready 1,0,0,1,0,1 then high
      Start = 1'b1; BaseAddr = 2'd0; Length = 3'd4;
      stalled = 1'b0; held = '0; seen_done = 1'b0;
      for (int i = 0; i < 30 && !seen_done; i++) begin
         @(posedge clk);
         #1;
         Start = 1'b0;
         @(negedge clk);
         if (stalled) begin
            check("b3.stall_valid", 32'(StreamValid), 1);
            check("b3.stall_data", 32'(StreamData), 32'(held));
         end
         if (Done) seen_done = 1'b1;
         StreamReady = (i < 6) ? pat3[i][0] : 1'b1;
         if (StreamValid && StreamReady) q3.push_back(StreamData);
         stalled = StreamValid && !StreamReady;
         held    = StreamData;
      end
      StreamReady = 1'b1;
      check("b3.done_seen", 32'(seen_done), 1);
      check("b3.busy_end", 32'(Busy), 0);
      check("b3.count", 32'(q3.size()), 4);
      for (int j = 0; j < 4; j++) begin
         got = (j < q3.size()) ? 32'(q3[j]) : 32'hffff_ffff;
         check($sformatf("b3.word%0d", j), got, exp3[j]);
      end

      // Zero length: Done next cycle, nothing else moves
      Start = 1'b1; BaseAddr = 2'd2; Length = 3'd0;
      expect_cycle("b4.c1", 0, 1, 0, -1, 3);
      expect_cycle("b4.c2", 0, 0, 0, -1, 3);
      expect_cycle("b4.c3", 0, 0, 0, -1, 3);

      // Start mid-burst is ignored
      Start = 1'b1; BaseAddr = 2'd1; Length = 3'd4;
      expect_cycle("b5.c1", 1, 0, 0, -1, 1);
      Start = 1'b1; BaseAddr = 2'd2; Length = 3'd1;
      expect_cycle("b5.c2", 1, 0, 0, -1, 2);
      expect_cycle("b5.c3", 1, 0, 1, 2, 3);
      expect_cycle("b5.c4", 1, 0, 1, 3, 0);
      expect_cycle("b5.c5", 1, 0, 1, 0, 0);
      expect_cycle("b5.c6", 1, 0, 1, 1, 0);
      expect_cycle("b5.c7", 0, 1, 0, -1, 0);

      // Reset after the second transfer aborts the burst
      Start = 1'b1; BaseAddr = 2'd0; Length = 3'd4;
      expect_cycle("b6.c1", 1, 0, 0, -1, 0);
      expect_cycle("b6.c2", 1, 0, 0, -1, 1);
      expect_cycle("b6.c3", 1, 0, 1, 1, 2);
      expect_cycle("b6.c4", 1, 0, 1, 2, 3);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("b6.rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("b6.idle_busy", 32'(Busy), 0);
      check("b6.idle_done", 32'(Done), 0);
      check("b6.idle_valid", 32'(StreamValid), 0);
      expect_cycle("b6.after", 0, 0, 0, -1, 0);

      // Normal burst after the abort
      Start = 1'b1; BaseAddr = 2'd2; Length = 3'd2;
      expect_cycle("b7.c1", 1, 0, 0, -1, 2);
      expect_cycle("b7.c2", 1, 0, 0, -1, 3);
      expect_cycle("b7.c3", 1, 0, 1, 3, 3);
      expect_cycle("b7.c4", 1, 0, 1, 0, 3);
      expect_cycle("b7.c5", 0, 1, 0, -1, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/soc_fpga_ram_code_reader.md
SOC_FPGA_RAM_CODE_READER -- requirements
Module: soc_fpga_ram_code_reader

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 2, RAM word width in bits.
REQ-002 The block SHALL have parameter ADDRWIDTH, default 2, RAM address width; RAM depth is 2**ADDRWIDTH.
REQ-003 The block SHALL have port PortAClk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port PortAResetn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port Start  input  1  request a burst read; sampled only in IDLE.
REQ-006 The block SHALL have port BaseAddr  input  ADDRWIDTH  first word address; sampled with Start.
REQ-007 The block SHALL have port Length  input  ADDRWIDTH+1  word count, 0..2**ADDRWIDTH; sampled with Start.
REQ-008 The block SHALL have port Busy  output  1  high from the cycle after an accepted Start until the cycle Done is high.
REQ-009 The block SHALL have port Done  output  1  one-cycle pulse at burst completion.
REQ-010 The block SHALL have port PortAAddr  output  ADDRWIDTH  RAM address.
REQ-011 The block SHALL have port PortAWriteEnable  output  1  RAM write enable; constant 0.
REQ-012 The block SHALL have port PortADataIn  output  DATAWIDTH  RAM write data; constant 0.
REQ-013 The block SHALL have port PortADataOut  input  DATAWIDTH  RAM registered read data; reflects the address presented in the previous cycle.
REQ-014 The block SHALL have port StreamData  output  DATAWIDTH  output word.
REQ-015 The block SHALL have port StreamValid  output  1  StreamData valid.
REQ-016 The block SHALL have port StreamReady  input  1  consumer accepts; a transfer occurs when StreamValid and StreamReady are both high at a rising edge.

Function
REQ-017 The FSM SHALL have states IDLE, READ and DRAIN: IDLE->READ on Start with Length!=0; READ->DRAIN when the last address is issued; DRAIN->IDLE on the transfer of the last word, with Done asserted in the following cycle.
REQ-018 Start with Length==0 in IDLE SHALL produce a Done pulse in the next cycle, issue no reads, and leave Busy low.
REQ-019 Start while not IDLE SHALL be ignored, including BaseAddr and Length.
REQ-020 Read i, for i=0..Length-1, SHALL present PortAAddr = (BaseAddr+i) mod 2**ADDRWIDTH, wrapping through 0 without error.
REQ-021 The data for a read issued in cycle c SHALL be captured from PortADataOut at the end of cycle c+1 into a 2-entry output FIFO.
REQ-022 A read SHALL be issued only if FIFO occupancy plus outstanding reads, less any transfer in the same cycle, is below 2; no captured word is ever dropped or overwritten.
REQ-023 With StreamReady held high, the first StreamValid SHALL occur 3 cycles after the Start edge, and one word SHALL then transfer per cycle.
REQ-024 Under backpressure, StreamData and StreamValid SHALL hold stable until a transfer occurs.
REQ-025 Words SHALL be emitted in address order, exactly Length words per burst.
REQ-026 In IDLE, PortAAddr SHALL hold its last value and StreamValid SHALL be 0.

Reset
REQ-027 While PortAResetn is low, all outputs SHALL be forced immediately to 0: Busy, Done, StreamValid, StreamData, PortAAddr. The FSM SHALL be in IDLE, the FIFO empty and the outstanding-read count 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no Done; the first cycle after release SHALL be IDLE.

Verification
REQ-029 RAM = {0:1,1:2,2:3,3:0}; Start with BaseAddr=0, Length=4, StreamReady=1 -> StreamData 1,2,3,0 on 4 consecutive cycles starting 3 cycles after Start; Done 1 cycle after the last transfer.
REQ-030 BaseAddr=3, Length=3 -> PortAAddr sequence 3,0,1; data mem[3],mem[0],mem[1].
REQ-031 StreamReady toggled 1,0,0,1,0,1 during a Length=4 burst -> all 4 words delivered in order, none duplicated, data stable while stalled.
REQ-032 Length=0 -> Done pulse next cycle; StreamValid never high; Busy stays 0.
REQ-033 Start pulsed again mid-burst with a different BaseAddr -> ignored; the original burst completes unchanged.
REQ-034 PortAResetn pulsed low after the second transfer of a Length=4 burst -> outputs 0 immediately, no Done; a new Start afterwards runs a normal burst.
